accel_cmd_issuer: RTL and testbench

CPU-side initiator for the Accel instruction port. It accepts one packed convolution job descriptor over a valid/ready handshake. It then drives the full configuration sequence of EXTEND_OPCODE register writes onto `instruction`, one per cycle, ending with the trigger. It then waits for `accel_done` and reports completion, the captured `accel_interrupt` value, or a timeout.

---
 rtl/accel_cmd_issuer_pkg.sv | 90 +++++++++
 rtl/accel_cmd_rom.sv | 28 ++
 rtl/accel_cmd_issuer.sv | 121 ++++++++++++
 tb/tb_accel_cmd_issuer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_cmd_issuer_pkg.sv
// Shared constants and types for the Accel command issuer:
// instruction encoding, register codes and descriptor layout.
package accel_cmd_issuer_pkg;

    localparam logic [6:0] EXTEND_OPCODE = 7'b0001011;

    localparam logic [4:0] RD_IMAGE_DIM       = 5'd1;
    localparam logic [4:0] RD_IMAGE_DEPTH     = 5'd2;
    localparam logic [4:0] RD_IMAGE_OFFSET    = 5'd3;
    localparam logic [4:0] RD_FILTER_OFFSET   = 5'd4;
    localparam logic [4:0] RD_OUTPUT_OFFSET   = 5'd5;
    localparam logic [4:0] RD_FILTER_HALFSIZE = 5'd6;
    localparam logic [4:0] RD_FILTER_STRIDE   = 5'd7;
    localparam logic [4:0] RD_FILTER_LENGTH   = 5'd8;
    localparam logic [4:0] RD_FILTER_BIAS     = 5'd9;
    localparam logic [4:0] RD_ACCEL_INTERRUPT = 5'd10;
    localparam logic [4:0] RD_TRIGGER_ACCEL   = 5'd11;

    localparam int FIELD_W    = 20;
    localparam int NUM_FIELDS = 10;
    localparam int BUNDLE_W   = FIELD_W * NUM_FIELDS;
    localparam int SEQ_LEN    = 11;
    localparam int IDX_W      = 4;

    localparam int OFS_IMAGE_DIM       = 0;
    localparam int OFS_IMAGE_DEPTH     = 20;
    localparam int OFS_IMAGE_OFFSET    = 40;
    localparam int OFS_FILTER_OFFSET   = 60;
    localparam int OFS_OUTPUT_OFFSET   = 80;
    localparam int OFS_FILTER_HALFSIZE = 100;
    localparam int OFS_FILTER_STRIDE   = 120;
    localparam int OFS_FILTER_LENGTH   = 140;
    localparam int OFS_FILTER_BIAS     = 160;
    localparam int OFS_INTERRUPT_TAG   = 180;

    typedef enum logic [3:0] {
        FS_IMAGE_DIM,
        FS_IMAGE_DEPTH,
        FS_IMAGE_OFFSET,
        FS_FILTER_OFFSET,
        FS_OUTPUT_OFFSET,
        FS_FILTER_HALFSIZE,
        FS_FILTER_STRIDE,
        FS_FILTER_LENGTH,
        FS_FILTER_BIAS,
        FS_INTERRUPT_TAG,
        FS_ZERO
    } field_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    typedef struct packed {
        logic [4:0] rd;
        field_sel_e sel;
    } rom_entry_t;

    function automatic logic [31:0] make_instr(
        input logic [FIELD_W-1:0] imm,
        input logic [4:0]         rd
    );
        return {imm, rd, EXTEND_OPCODE};
    endfunction

    function automatic logic [FIELD_W-1:0] field_of(
        input logic [BUNDLE_W-1:0] b,
        input field_sel_e          s
    );
        logic [FIELD_W-1:0] f;
        f = '0;
        unique case (s)
            FS_IMAGE_DIM:       f = b[OFS_IMAGE_DIM       +: FIELD_W];
            FS_IMAGE_DEPTH:     f = b[OFS_IMAGE_DEPTH     +: FIELD_W];
            FS_IMAGE_OFFSET:    f = b[OFS_IMAGE_OFFSET    +: FIELD_W];
            FS_FILTER_OFFSET:   f = b[OFS_FILTER_OFFSET   +: FIELD_W];
            FS_OUTPUT_OFFSET:   f = b[OFS_OUTPUT_OFFSET   +: FIELD_W];
            FS_FILTER_HALFSIZE: f = b[OFS_FILTER_HALFSIZE +: FIELD_W];
            FS_FILTER_STRIDE:   f = b[OFS_FILTER_STRIDE   +: FIELD_W];
            FS_FILTER_LENGTH:   f = b[OFS_FILTER_LENGTH   +: FIELD_W];
            FS_FILTER_BIAS:     f = b[OFS_FILTER_BIAS     +: FIELD_W];
            FS_INTERRUPT_TAG:   f = b[OFS_INTERRUPT_TAG   +: FIELD_W];
            default:            f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/accel_cmd_rom.sv
// Configuration sequence table: issue index -> register code
// and the descriptor field that supplies its immediate.
module accel_cmd_rom
    import accel_cmd_issuer_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output rom_entry_t       entry
);

    always_comb begin
        entry = '{rd: 5'd0, sel: FS_ZERO};
        unique case (idx)
            4'd0:  entry = '{rd: RD_IMAGE_DIM,       sel: FS_IMAGE_DIM};
            4'd1:  entry = '{rd: RD_IMAGE_DEPTH,     sel: FS_IMAGE_DEPTH};
            4'd2:  entry = '{rd: RD_IMAGE_OFFSET,    sel: FS_IMAGE_OFFSET};
            4'd3:  entry = '{rd: RD_FILTER_OFFSET,   sel: FS_FILTER_OFFSET};
            4'd4:  entry = '{rd: RD_OUTPUT_OFFSET,   sel: FS_OUTPUT_OFFSET};
            4'd5:  entry = '{rd: RD_FILTER_HALFSIZE, sel: FS_FILTER_HALFSIZE};
            4'd6:  entry = '{rd: RD_FILTER_STRIDE,   sel: FS_FILTER_STRIDE};
            4'd7:  entry = '{rd: RD_FILTER_LENGTH,   sel: FS_FILTER_LENGTH};
            4'd8:  entry = '{rd: RD_FILTER_BIAS,     sel: FS_FILTER_BIAS};
            4'd9:  entry = '{rd: RD_ACCEL_INTERRUPT, sel: FS_INTERRUPT_TAG};
            4'd10: entry = '{rd: RD_TRIGGER_ACCEL,   sel: FS_ZERO};
            default: entry = '{rd: 5'd0, sel: FS_ZERO};
        endcase
    end

endmodule

// File: rtl/accel_cmd_issuer.sv
// Accel instruction-port initiator: accepts a job descriptor,
// issues the register-write sequence, then waits for completion.
module accel_cmd_issuer
    import accel_cmd_issuer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input  logic                clk,
    input  logic                rst_ext,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [BUNDLE_W-1:0] cfg_bundle,
    input  logic                abort,
    output logic [31:0]         instruction,
    input  logic                accel_done,
    input  logic [18:0]         accel_interrupt,
    output logic                busy,
    output logic                job_done,
    output logic                job_timeout,
    output logic [18:0]         irq_status
);

    state_e              state;
    logic [BUNDLE_W-1:0] shadow;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    wait_cnt;

    logic [IDX_W-1:0]    rom_idx;
    rom_entry_t          rom_entry;
    logic [BUNDLE_W-1:0] field_src;
    logic [31:0]         next_word;
    logic                accept;
    logic                last_word;
    logic                timeout_hit;

    assign cfg_ready = (state == ST_IDLE);
    assign accept    = cfg_valid && cfg_ready;

    // Word 0 is launched on the accept edge straight from the input bundle;
    // later words look one entry ahead of the word currently on the port.
    assign rom_idx   = (state == ST_IDLE) ? '0 : idx + 1'b1;
    assign field_src = (state == ST_IDLE) ? cfg_bundle : shadow;

    accel_cmd_rom u_rom (
        .idx   (rom_idx),
        .entry (rom_entry)
    );

    assign next_word   = make_instr(field_of(field_src, rom_entry.sel),
                                    rom_entry.rd);
    assign last_word   = (idx == IDX_W'(SEQ_LEN - 1));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            state       <= ST_IDLE;
            shadow      <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            instruction <= '0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            job_timeout <= 1'b0;
            irq_status  <= '0;
        end else begin
            job_done    <= 1'b0;
            job_timeout <= 1'b0;
            if (abort) begin
                state       <= ST_IDLE;
                idx         <= '0;
                wait_cnt    <= '0;
                instruction <= '0;
                busy        <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            shadow      <= cfg_bundle;
                            idx         <= '0;
                            instruction <= next_word;
                            busy        <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        if (last_word) begin
                            instruction <= '0;
                            wait_cnt    <= '0;
                            state       <= ST_WAIT;
                        end else begin
                            instruction <= next_word;
                            idx         <= idx + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        // Completion takes priority over a coincident timeout.
                        if (accel_done) begin
                            irq_status <= accel_interrupt;
                            job_done   <= 1'b1;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end else if (timeout_hit) begin
                            job_timeout <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end else if (TIMEOUT_CYCLES != 0) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_accel_cmd_issuer.sv
// Scoreboard bench for accel_cmd_issuer: random descriptors, a stub
// Accel, abort/reset/timeout corners and back-to-back acceptance.
module tb_accel_cmd_issuer;
    import accel_cmd_issuer_pkg::*;

    localparam int TO = 16;

    localparam logic [4:0] RD_ORDER [11] = '{
        RD_IMAGE_DIM, RD_IMAGE_DEPTH, RD_IMAGE_OFFSET, RD_FILTER_OFFSET,
        RD_OUTPUT_OFFSET, RD_FILTER_HALFSIZE, RD_FILTER_STRIDE,
        RD_FILTER_LENGTH, RD_FILTER_BIAS, RD_ACCEL_INTERRUPT,
        RD_TRIGGER_ACCEL
    };

    logic         clk = 1'b0;
    logic         rst_ext;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [199:0] cfg_bundle;
    logic         abort;
    logic [31:0]  instruction;
    logic         accel_done;
    logic [18:0]  accel_interrupt;
    logic         busy;
    logic         job_done;
    logic         job_timeout;
    logic [18:0]  irq_status;

    accel_cmd_issuer #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk             (clk),
        .rst_ext         (rst_ext),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_bundle      (cfg_bundle),
        .abort           (abort),
        .instruction     (instruction),
        .accel_done      (accel_done),
        .accel_interrupt (accel_interrupt),
        .busy            (busy),
        .job_done        (job_done),
        .job_timeout     (job_timeout),
        .irq_status      (irq_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        bit          last;
    } exp_word_t;

    typedef struct {
        bit          is_done;
        logic [18:0] irq;
    } exp_evt_t;

    exp_word_t   exp_words[$];
    exp_evt_t    exp_evts[$];
    int          total  = 0;
    int          passed = 0;
    logic [18:0] model_irq = '0;
    bit          expect_more = 0;
    bit          prev_pulse = 0;
    int          cyc = 0;
    exp_word_t   mw;
    exp_evt_t    me;

    localparam logic [31:0] TRIG_WORD = {20'd0, RD_TRIGGER_ACCEL, EXTEND_OPCODE};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: immediate in bits 31:12, register code in 11:7, opcode below.
    function automatic logic [31:0] ref_word(input logic [199:0] b, input int i);
        logic [19:0] imm;
        imm = (i == 10) ? 20'd0 : 20'(b >> (20 * i));
        return (32'(imm) << 12) | (32'(RD_ORDER[i]) << 7) | 32'(EXTEND_OPCODE);
    endfunction

    task automatic push_words(input logic [199:0] b, input int n);
        for (int i = 0; i < n; i++)
            exp_words.push_back('{word: ref_word(b, i), last: (i == n - 1)});
    endtask

    function automatic logic [199:0] pack10(
        input logic [19:0] f0, f1, f2, f3, f4, f5, f6, f7, f8, f9);
        return {f9, f8, f7, f6, f5, f4, f3, f2, f1, f0};
    endfunction

    function automatic logic [199:0] rand_desc();
        logic [199:0] b;
        b = '0;
        for (int i = 0; i < 7; i++) b = (b << 32) | 200'($urandom);
        return b;
    endfunction

    // Monitor: every nonzero word and every pulse is popped from the scoreboard.
    always @(negedge clk) begin
        if (rst_ext) begin
            expect_more = 0;
            prev_pulse  = 0;
        end else begin
            if (instruction != 32'd0) begin
                if (exp_words.size() == 0) begin
                    check(0, "unexpected_word", instruction, 0);
                end else begin
                    mw = exp_words.pop_front();
                    check(instruction == mw.word, "instr_word", instruction, mw.word);
                    expect_more = !mw.last;
                end
            end else if (expect_more) begin
                check(0, "word_gap", instruction, exp_words.size() ? exp_words[0].word : 0);
                expect_more = 0;
            end
            if (job_done || job_timeout) begin
                if (prev_pulse) check(0, "pulse_width", 2, 1);
                if (exp_evts.size() == 0) begin
                    check(0, "unexpected_pulse", {job_done, job_timeout}, 0);
                end else begin
                    me = exp_evts.pop_front();
                    check({job_done, job_timeout} == (me.is_done ? 2'b10 : 2'b01),
                          "pulse_kind", {job_done, job_timeout},
                          me.is_done ? 2'b10 : 2'b01);
                    check(irq_status == me.irq, "irq_status", irq_status, me.irq);
                end
            end
            prev_pulse = job_done || job_timeout;
        end
    end

    // d < 0: done already high before accept; d >= TO: stub never answers.
    task automatic run_job(input logic [199:0] desc, input int d,
                           input logic [18:0] irq, input int abort_at,
                           input bit hold_valid, input bit expect_now);
        int n;
        int t0;
        int exp_lat;
        cfg_bundle = desc;
        cfg_valid  = 1'b1;
        if (d < 0) begin
            accel_done      = 1'b1;
            accel_interrupt = irq;
        end else begin
            accel_done = 1'b0;
        end
        if (abort_at >= 0) begin
            push_words(desc, abort_at + 1);
        end else begin
            push_words(desc, 11);
            if (d < TO) begin
                exp_evts.push_back('{is_done: 1'b1, irq: irq});
                model_irq = irq;
            end else begin
                exp_evts.push_back('{is_done: 1'b0, irq: model_irq});
            end
        end
        n = 0;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(cfg_ready, "ready_wait", cfg_ready, 1);
        if (expect_now) check(n == 0, "b2b_accept", n, 0);
        @(posedge clk);
        #1;
        if (hold_valid) cfg_bundle = ~desc;
        else cfg_valid = 1'b0;
        @(negedge clk);
        check(busy == 1'b1, "busy_after_accept", busy, 1);
        check(cfg_ready == 1'b0, "ready_low_busy", cfg_ready, 0);
        if (abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #1 abort = 1'b1;
            @(posedge clk);
            #1 abort = 1'b0;
            @(negedge clk);
            check(instruction == 32'd0, "abort_instr", instruction, 0);
            check(busy == 1'b0, "abort_busy", busy, 0);
            repeat (20) @(negedge clk);
            return;
        end
        n = 0;
        while (instruction != TRIG_WORD && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(instruction == TRIG_WORD, "trigger_seen", instruction, TRIG_WORD);
        t0 = cyc;
        if (d >= 0) begin
            accel_interrupt = irq;
            if (d < TO) begin
                repeat (d + 1) @(posedge clk);
                #1 accel_done = 1'b1;
            end
        end
        n = 0;
        while (!(job_done || job_timeout) && n < 60) begin
            @(negedge clk);
            n++;
        end
        exp_lat = (d < 0) ? 2 : (d < TO) ? d + 2 : TO + 1;
        check(cyc - t0 == exp_lat, "completion_latency", cyc - t0, exp_lat);
        accel_done = 1'b0;
        check(cfg_ready == 1'b1, "ready_after_job", cfg_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] plan_desc;
        logic [199:0] desc;
        rst_ext         = 1'b1;
        cfg_valid       = 1'b0;
        cfg_bundle      = '0;
        abort           = 1'b0;
        accel_done      = 1'b0;
        accel_interrupt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(instruction == 32'd0, "rst_instr", instruction, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(cfg_ready == 1'b1, "rst_ready", cfg_ready, 1);
        check(irq_status == 19'd0, "rst_irq", irq_status, 0);
        check({job_done, job_timeout} == 2'b00, "rst_pulses", {job_done, job_timeout}, 0);
        rst_ext = 1'b0;
        @(negedge clk);

        plan_desc = pack10(20'd5, 20'd3, 20'd0, 20'd76, 20'd86,
                           20'd1, 20'd1, 20'd9, 20'd0, 20'hF00BA);
        run_job(plan_desc, 10, 19'h0F00B, -1, 0, 0);
        check(irq_status == 19'h0F00B, "plan_irq", irq_status, 19'h0F00B);
        run_job(plan_desc, 999, 19'h12345, -1, 0, 0);
        check(irq_status == 19'h0F00B, "timeout_irq_held", irq_status, 19'h0F00B);
        run_job(rand_desc(), TO - 1, 19'h2AAAA, -1, 0, 0);
        run_job(rand_desc(), TO, 19'h15555, -1, 0, 0);
        run_job(rand_desc(), -1, 19'h7BEEF, -1, 0, 0);
        run_job(plan_desc, 0, 19'h0, 4, 0, 0);
        run_job(rand_desc(), 3, 19'h01234, -1, 1, 0);
        run_job(rand_desc(), 5, 19'h04321, -1, 0, 1);

        for (int k = 0; k < 12; k++) begin
            desc = rand_desc();
            if ($urandom_range(0, 3) == 0)
                run_job(desc, 0, 19'h0, $urandom_range(0, 9), 0, 0);
            else
                run_job(desc, $urandom_range(0, 20), 19'($urandom), -1, 0, 0);
        end

        desc = rand_desc();
        cfg_bundle = desc;
        cfg_valid  = 1'b1;
        push_words(desc, 11);
        while (!cfg_ready) @(negedge clk);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        for (int n = 0; n < 40 && instruction != TRIG_WORD; n++) @(negedge clk);
        repeat (5) @(posedge clk);
        #1 rst_ext = 1'b1;
        @(posedge clk);
        #1 rst_ext = 1'b0;
        @(negedge clk);
        check(instruction == 32'd0, "midwait_rst_instr", instruction, 0);
        check(busy == 1'b0, "midwait_rst_busy", busy, 0);
        check(cfg_ready == 1'b1, "midwait_rst_ready", cfg_ready, 1);
        check(irq_status == 19'd0, "midwait_rst_irq", irq_status, 0);
        check({job_done, job_timeout} == 2'b00, "midwait_rst_pulses",
              {job_done, job_timeout}, 0);
        repeat (25) @(negedge clk);

        check(exp_words.size() == 0, "words_left", exp_words.size(), 0);
        check(exp_evts.size() == 0, "events_left", exp_evts.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
